// File: rtl/dcf77_encoder.sv
// DCF77 time-code encoder: assembles a 59-bit minute frame from BCD inputs
// and produces the demodulated DCF77 pulse train (100 ms / 200 ms pulses,
// with a pulse-free second 59 as the minute marker).
module dcf77_encoder #(
    parameter int CLOCK_FREQUENCY = 16000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        load,
    output logic        ready,
    input  logic [18:0] din_flags,
    input  logic [6:0]  din_minute,
    input  logic [5:0]  din_hour,
    input  logic [21:0] din_date,
    output logic        dcf_out,
    output logic [5:0]  second,
    output logic        minute_start
);

    localparam int TICK_DIV = CLOCK_FREQUENCY / 10;
    localparam int PW       = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
    // Frame with nothing loaded: only the start-of-time bit 20 set, parities of zero.
    localparam logic [58:0] FRAME_RST = {38'd0, 1'b1, 20'd0};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GAP  = 2'd1,
        BITS = 2'd2
    } state_e;

    // Even parity over an arbitrary-width field (zero-extended to 22 bits).
    function automatic logic even_parity(input logic [21:0] v);
        return ^v;
    endfunction

    // Shadow layout {date, hour, minute, flags} -> transmitted frame bits 0..58.
    function automatic logic [58:0] assemble_frame(input logic [53:0] sh);
        logic [18:0] fl;
        logic [6:0]  mi;
        logic [5:0]  hr;
        logic [21:0] dt;
        fl = sh[18:0];
        mi = sh[25:19];
        hr = sh[31:26];
        dt = sh[53:32];
        return {even_parity(dt), dt,
                even_parity({16'd0, hr}), hr,
                even_parity({15'd0, mi}), mi,
                1'b1, fl, 1'b0};
    endfunction

    state_e         state_q, state_d;
    logic [PW-1:0]  presc_q, presc_d;
    logic [3:0]     tenth_q, tenth_d;
    logic [5:0]     second_q, second_d;
    logic [58:0]    frame_q, frame_d;
    logic [53:0]    shadow_q, shadow_d;
    logic           pending_q, pending_d;
    logic           dcf_out_q, dcf_out_d;
    logic           minute_start_q, minute_start_d;
    logic           tick_s, sec_end_s, accept_s, frame_bit_s;

    assign ready        = ~pending_q;
    assign dcf_out      = dcf_out_q;
    assign second       = second_q;
    assign minute_start = minute_start_q;

    // State, timing counters, frame/shadow storage and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            presc_q        <= {PW{1'b0}};
            tenth_q        <= 4'd0;
            second_q       <= 6'd0;
            frame_q        <= FRAME_RST;
            shadow_q       <= 54'd0;
            pending_q      <= 1'b0;
            dcf_out_q      <= 1'b0;
            minute_start_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            presc_q        <= presc_d;
            tenth_q        <= tenth_d;
            second_q       <= second_d;
            frame_q        <= frame_d;
            shadow_q       <= shadow_d;
            pending_q      <= pending_d;
            dcf_out_q      <= dcf_out_d;
            minute_start_q <= minute_start_d;
        end
    end

    // Next-state logic: FSM sequencing, counters, frame hand-over and pulse shaping.
    always_comb begin
        state_d        = state_q;
        presc_d        = presc_q;
        tenth_d        = tenth_q;
        second_d       = second_q;
        frame_d        = frame_q;
        shadow_d       = shadow_q;
        pending_d      = pending_q;
        minute_start_d = 1'b0;
        dcf_out_d      = 1'b0;
        frame_bit_s    = 1'b0;
        tick_s         = (presc_q == TICK_LAST);
        sec_end_s      = tick_s && (tenth_q == 4'd9);
        accept_s       = load && !pending_q;

        if (!enable) begin
            state_d  = IDLE;
            presc_d  = {PW{1'b0}};
            tenth_d  = 4'd0;
            second_d = 6'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d  = GAP;
                    presc_d  = {PW{1'b0}};
                    tenth_d  = 4'd0;
                    second_d = 6'd59;
                end
                GAP, BITS: begin
                    if (tick_s) begin
                        presc_d = {PW{1'b0}};
                        if (tenth_q == 4'd9) begin
                            tenth_d = 4'd0;
                        end else begin
                            tenth_d = tenth_q + 4'd1;
                        end
                    end else begin
                        presc_d = presc_q + PW'(1);
                        tenth_d = tenth_q;
                    end
                    if (!sec_end_s) begin
                        second_d = second_q;
                    end else if (state_q == GAP) begin
                        // Minute boundary: hand a pending shadow over to the frame.
                        state_d        = BITS;
                        second_d       = 6'd0;
                        minute_start_d = 1'b1;
                        if (pending_q) begin
                            frame_d   = assemble_frame(shadow_q);
                            pending_d = 1'b0;
                        end else begin
                            frame_d   = frame_q;
                        end
                    end else if (second_q == 6'd58) begin
                        state_d  = GAP;
                        second_d = 6'd59;
                    end else begin
                        second_d = second_q + 6'd1;
                    end
                end
                default: begin
                    state_d  = IDLE;
                    presc_d  = {PW{1'b0}};
                    tenth_d  = 4'd0;
                    second_d = 6'd0;
                end
            endcase
        end

        // A load in the hand-over cycle only reaches the shadow; the frame took the old one.
        if (accept_s) begin
            shadow_d  = {din_date, din_hour, din_minute, din_flags};
            pending_d = 1'b1;
        end else begin
            shadow_d  = shadow_q;
        end

        // Pulse computed from next-cycle values so dcf_out lines up with second/tenth.
        if (second_d <= 6'd58) begin
            frame_bit_s = frame_d[second_d];
        end else begin
            frame_bit_s = 1'b0;
        end
        if (state_d == BITS) begin
            dcf_out_d = (tenth_d == 4'd0) || ((tenth_d == 4'd1) && frame_bit_s);
        end else begin
            dcf_out_d = 1'b0;
        end
    end

endmodule

// File: tb/tb_dcf77_encoder.sv
// Self-checking bench for dcf77_encoder at CLOCK_FREQUENCY=100
// (tick = 10 cycles, second = 100 cycles, minute = 6000 cycles).
module tb_dcf77_encoder;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic        load = 1'b0;
    logic        ready;
    logic [18:0] din_flags = 19'd0;
    logic [6:0]  din_minute = 7'd0;
    logic [5:0]  din_hour = 6'd0;
    logic [21:0] din_date = 22'd0;
    logic        dcf_out;
    logic [5:0]  second;
    logic        minute_start;

    dcf77_encoder #(.CLOCK_FREQUENCY(100)) dut (
        .clk(clk), .reset(reset), .enable(enable), .load(load), .ready(ready),
        .din_flags(din_flags), .din_minute(din_minute), .din_hour(din_hour),
        .din_date(din_date), .dcf_out(dcf_out), .second(second),
        .minute_start(minute_start)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    // Reference model: position within the 60 s cycle (0..99 = marker second 59).
    bit          m_active;
    int          m_pos;
    bit          m_pending;
    logic [18:0] m_fl;
    logic [6:0]  m_mi;
    logic [5:0]  m_hr;
    logic [21:0] m_dt;
    logic [58:0] m_frame, m_done_frame;

    int plen[60];
    int prev_plen[60];
    int plen_a[60];
    int frames_done = 0;

    typedef struct {
        logic [6:0]  mi;
        logic [5:0]  hr;
        logic [18:0] fl;
        logic [21:0] dt;
        int          sec;
        int          len;
    } vec_t;
    vec_t vecs[$];

    function automatic vec_t mkv(logic [6:0] mi, logic [5:0] hr, logic [18:0] fl,
                                 logic [21:0] dt, int sec, int len);
        vec_t v;
        v.mi = mi; v.hr = hr; v.fl = fl; v.dt = dt; v.sec = sec; v.len = len;
        return v;
    endfunction

    function automatic logic [58:0] ref_frame(logic [18:0] fl, logic [6:0] mi,
                                              logic [5:0] hr, logic [21:0] dt);
        logic [58:0] f;
        f = 59'd0;
        for (int i = 0; i < 19; i++) f[1 + i] = fl[i];
        f[20] = 1'b1;
        for (int i = 0; i < 7; i++) f[21 + i] = mi[i];
        f[28] = ^mi;
        for (int i = 0; i < 6; i++) f[29 + i] = hr[i];
        f[35] = ^hr;
        for (int i = 0; i < 22; i++) f[36 + i] = dt[i];
        f[58] = ^dt;
        return f;
    endfunction

    function automatic int exp_len(logic [58:0] f, int s);
        if (s == 59) return 0;
        return f[s] ? 20 : 10;
    endfunction

    task automatic chk(input string nm, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s @%0t: got %0d expected %0d", nm, $time, act, exp);
    endtask

    task automatic model_reset();
        m_active = 0; m_pos = 0; m_pending = 0;
        m_fl = 19'd0; m_mi = 7'd0; m_hr = 6'd0; m_dt = 22'd0;
        m_frame = ref_frame(19'd0, 7'd0, 6'd0, 22'd0);
        m_done_frame = m_frame;
        for (int s = 0; s < 60; s++) plen[s] = 0;
    endtask

    // One clock: advance the model with the inputs seen at the edge, then compare.
    task automatic step();
        bit acc;
        int s, tn;
        bit e_dcf;
        @(posedge clk);
        acc = load && !m_pending;
        if (!enable) begin
            m_active = 0; m_pos = 0;
        end else if (!m_active) begin
            m_active = 1; m_pos = 0;
        end else begin
            m_pos = (m_pos + 1) % 6000;
            if (m_pos == 100) begin
                m_done_frame = m_frame;
                if (m_pending) begin
                    m_frame = ref_frame(m_fl, m_mi, m_hr, m_dt);
                    m_pending = 0;
                end
            end
        end
        if (acc) begin
            m_fl = din_flags; m_mi = din_minute; m_hr = din_hour; m_dt = din_date;
            m_pending = 1;
        end
        #1;
        s  = m_active ? ((m_pos / 100) + 59) % 60 : 0;
        tn = (m_pos % 100) / 10;
        e_dcf = m_active && (s != 59) && ((tn == 0) || ((tn == 1) && m_frame[s]));
        chk("cyc_second", second, s);
        chk("cyc_dcf", dcf_out, e_dcf);
        chk("cyc_mstart", minute_start, m_active && (m_pos == 100));
        chk("cyc_ready", ready, !m_pending);
        if (!enable) for (int k = 0; k < 60; k++) plen[k] = 0;
        if (minute_start) begin
            prev_plen = plen;
            for (int k = 0; k < 60; k++) plen[k] = 0;
            frames_done++;
        end
        if (dcf_out && second < 60) plen[second]++;
    endtask

    task automatic run_until(input int target, input int budget);
        int n = 0;
        while (!(m_active && m_pos == target)) begin
            if (n >= budget) begin
                chk("timeout_run_until", 0, 1);
                break;
            end
            step();
            n++;
        end
    endtask

    task automatic wait_frames(input int nf);
        int start = frames_done;
        int n = 0;
        while (frames_done < start + nf) begin
            if (n >= 6200 * nf) begin
                chk("timeout_wait_frames", 0, 1);
                break;
            end
            step();
            n++;
        end
    endtask

    task automatic check_frame(input string nm);
        for (int s = 0; s < 60; s++) chk(nm, prev_plen[s], exp_len(m_done_frame, s));
    endtask

    task automatic load_and_run(input vec_t v);
        din_minute = v.mi; din_hour = v.hr; din_flags = v.fl; din_date = v.dt;
        load = 1'b1;
        step();
        load = 1'b0;
        chk("ready_low_after_load", ready, 0);
        wait_frames(2);
        check_frame("frame_loaded");
    endtask

    initial begin
        int n;
        logic [6:0]  cur_mi;
        logic [5:0]  cur_hr;
        logic [18:0] cur_fl;
        logic [21:0] cur_dt;

        // Data set 1: minute 0x25, hour 0x13, flags/date 0.
        vecs.push_back(mkv(7'h25, 6'h13, 19'h0, 22'h0, 0, 10));
        vecs.push_back(mkv(7'h25, 6'h13, 19'h0, 22'h0, 1, 10));
        vecs.push_back(mkv(7'h25, 6'h13, 19'h0, 22'h0, 20, 20));
        vecs.push_back(mkv(7'h25, 6'h13, 19'h0, 22'h0, 21, 20));
        vecs.push_back(mkv(7'h25, 6'h13, 19'h0, 22'h0, 22, 10));
        vecs.push_back(mkv(7'h25, 6'h13, 19'h0, 22'h0, 23, 20));
        vecs.push_back(mkv(7'h25, 6'h13, 19'h0, 22'h0, 26, 20));
        vecs.push_back(mkv(7'h25, 6'h13, 19'h0, 22'h0, 27, 10));
        vecs.push_back(mkv(7'h25, 6'h13, 19'h0, 22'h0, 28, 20));
        vecs.push_back(mkv(7'h25, 6'h13, 19'h0, 22'h0, 29, 20));
        vecs.push_back(mkv(7'h25, 6'h13, 19'h0, 22'h0, 31, 10));
        vecs.push_back(mkv(7'h25, 6'h13, 19'h0, 22'h0, 35, 20));
        vecs.push_back(mkv(7'h25, 6'h13, 19'h0, 22'h0, 58, 10));
        vecs.push_back(mkv(7'h25, 6'h13, 19'h0, 22'h0, 59, 0));
        // Data set 2: exercises flags, date and a zero minute parity.
        vecs.push_back(mkv(7'h59, 6'h23, 19'h40001, 22'h2A5A5, 1, 20));
        vecs.push_back(mkv(7'h59, 6'h23, 19'h40001, 22'h2A5A5, 2, 10));
        vecs.push_back(mkv(7'h59, 6'h23, 19'h40001, 22'h2A5A5, 19, 20));
        vecs.push_back(mkv(7'h59, 6'h23, 19'h40001, 22'h2A5A5, 24, 20));
        vecs.push_back(mkv(7'h59, 6'h23, 19'h40001, 22'h2A5A5, 28, 10));
        vecs.push_back(mkv(7'h59, 6'h23, 19'h40001, 22'h2A5A5, 34, 20));
        vecs.push_back(mkv(7'h59, 6'h23, 19'h40001, 22'h2A5A5, 35, 20));
        vecs.push_back(mkv(7'h59, 6'h23, 19'h40001, 22'h2A5A5, 36, 20));
        vecs.push_back(mkv(7'h59, 6'h23, 19'h40001, 22'h2A5A5, 37, 10));
        vecs.push_back(mkv(7'h59, 6'h23, 19'h40001, 22'h2A5A5, 53, 20));
        vecs.push_back(mkv(7'h59, 6'h23, 19'h40001, 22'h2A5A5, 58, 20));
        vecs.push_back(mkv(7'h59, 6'h23, 19'h40001, 22'h2A5A5, 59, 0));

        // Reset state.
        model_reset();
        #23;
        chk("rst_dcf", dcf_out, 0);
        chk("rst_second", second, 0);
        chk("rst_mstart", minute_start, 0);
        chk("rst_ready", ready, 1);
        #4 reset = 1'b1;
        for (int i = 0; i < 3; i++) step();

        // First frame: load data set 1 and enable together.
        din_minute = 7'h25; din_hour = 6'h13; din_flags = 19'd0; din_date = 22'd0;
        load = 1'b1; enable = 1'b1;
        step();
        load = 1'b0;
        chk("ready_low_after_load", ready, 0);
        n = 0;
        while (!minute_start && n < 200) begin
            step();
            n++;
        end
        chk("gap_cycles_to_mstart", n, 100);
        chk("gap_pulses", prev_plen[59], 0);
        chk("ready_after_transfer", ready, 1);
        wait_frames(1);
        check_frame("frame_set1");
        cur_mi = 7'h25; cur_hr = 6'h13; cur_fl = 19'd0; cur_dt = 22'd0;

        // Table of probed pulse lengths; a new data set is loaded when it changes.
        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].mi != cur_mi || vecs[i].hr != cur_hr ||
                vecs[i].fl != cur_fl || vecs[i].dt != cur_dt) begin
                load_and_run(vecs[i]);
                cur_mi = vecs[i].mi; cur_hr = vecs[i].hr;
                cur_fl = vecs[i].fl; cur_dt = vecs[i].dt;
            end
            chk($sformatf("tbl_sec%0d", vecs[i].sec), prev_plen[vecs[i].sec], vecs[i].len);
        end

        // Repeated minute without reload.
        plen_a = prev_plen;
        wait_frames(1);
        for (int s = 0; s < 60; s++) chk("repeat_frame", prev_plen[s], plen_a[s]);
        chk("repeat_gap", prev_plen[59], 0);
        check_frame("frame_repeat");

        // Load exactly on the hand-over cycle (minute 0x01).
        run_until(99, 6100);
        din_minute = 7'h01;
        load = 1'b1;
        step();
        load = 1'b0;
        chk("handover_mstart", minute_start, 1);
        chk("handover_ready", ready, 0);
        // Load while busy must be ignored.
        run_until(600, 700);
        din_minute = 7'h25;
        load = 1'b1;
        step();
        load = 1'b0;
        chk("busy_load_ready", ready, 0);
        run_until(99, 6100);
        chk("ready_before_2nd_transfer", ready, 0);
        step();
        chk("ready_after_2nd_transfer", ready, 1);
        chk("old_frame_sec24", prev_plen[24], 20);
        check_frame("frame_old");
        wait_frames(1);
        chk("new_frame_sec21", prev_plen[21], 20);
        chk("new_frame_sec23", prev_plen[23], 10);
        chk("new_frame_sec24", prev_plen[24], 10);
        chk("new_frame_sec28", prev_plen[28], 20);
        check_frame("frame_new");

        // Enable dropped in the middle of the second-30 pulse.
        run_until(3105, 3200);
        chk("en_drop_pre_dcf", dcf_out, 1);
        enable = 1'b0;
        step();
        chk("en_drop_dcf", dcf_out, 0);
        chk("en_drop_second", second, 0);
        for (int i = 0; i < 5; i++) step();
        enable = 1'b1;
        step();
        wait_frames(1);
        chk("reenable_gap", prev_plen[59], 0);
        wait_frames(1);
        check_frame("frame_reenable");

        // Asynchronous reset during tenth 1 of bit 20.
        run_until(2115, 2200);
        chk("pre_reset_dcf", dcf_out, 1);
        #2 reset = 1'b0;
        #1;
        chk("async_rst_dcf", dcf_out, 0);
        chk("async_rst_ready", ready, 1);
        chk("async_rst_second", second, 0);
        chk("async_rst_mstart", minute_start, 0);
        model_reset();
        #1 reset = 1'b1;

        // Randomised traffic against the model.
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(0, 1999) == 0) enable = ~enable;
            load       = ($urandom_range(0, 99) == 0);
            din_minute = 7'($urandom);
            din_hour   = 6'($urandom);
            din_flags  = 19'($urandom);
            din_date   = 22'($urandom);
            step();
        end
        load = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/dcf77_encoder.md
DCF77_ENCODER -- requirements
Module: dcf77_encoder

Interface
REQ-001 SHALL have parameter CLOCK_FREQUENCY, default 16000000, clk frequency in Hz; CLOCK_FREQUENCY/10 SHALL be an integer >= 2.
REQ-002 SHALL have port clk  input  1  system clock; one clock domain, all logic on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset (asserted at 0).
REQ-004 SHALL have port enable  input  1  1 = generate frames, 0 = idle.
REQ-005 SHALL have port load  input  1  data-valid strobe, accepted when load && ready.
REQ-006 SHALL have port ready  output  1  1 = shadow register free, load accepted.
REQ-007 SHALL have port din_flags  input  19  frame bits 1..19 (din_flags[0] = bit 1).
REQ-008 SHALL have port din_minute  input  7  BCD minute, frame bits 21..27.
REQ-009 SHALL have port din_hour  input  6  BCD hour, frame bits 29..34.
REQ-010 SHALL have port din_date  input  22  day/weekday/month/year, frame bits 36..57.
REQ-011 SHALL have port dcf_out  output  1  demodulated DCF77 signal, 1 = pulse (carrier reduced).
REQ-012 SHALL have port second  output  6  current second index 0..59.
REQ-013 SHALL have port minute_start  output  1  one-cycle strobe at start of second 0.

Function
REQ-014 Prescaler SHALL count 0..CLOCK_FREQUENCY/10-1 and emit a one-cycle tick at wrap (100 ms).
REQ-015 Tenth counter SHALL count ticks 0..9; second SHALL increment on tenth wrap, 59 -> 0.
REQ-016 FSM states SHALL be IDLE, GAP, BITS.
REQ-017 IDLE: counters held at 0, dcf_out 0; enable=1 -> GAP with second=59, prescaler and tenth cleared.
REQ-018 GAP (second 59): dcf_out SHALL stay 0 for the full 1 s; at end -> BITS, second=0, minute_start=1 for one cycle.
REQ-019 BITS (seconds 0..58): dcf_out SHALL be 1 during tenth 0 for a 0-bit, tenths 0..1 for a 1-bit, else 0.
REQ-020 After second 58 ends, FSM SHALL go to GAP, second=59.
REQ-021 Frame SHALL be assembled as: bit0=0, bits1..19=din_flags, bit20=1, bits21..27 minute, bit28=^bits[27:21], bits29..34 hour, bit35=^bits[34:29], bits36..57 date, bit58=^bits[57:36] (even parity).
REQ-022 load && ready SHALL capture all din_* into a shadow register, set pending, drive ready=0 from next cycle.
REQ-023 At GAP->BITS transition: if pending, frame register SHALL take assembled shadow and pending SHALL clear (ready=1 next cycle); otherwise previous frame SHALL repeat unchanged.
REQ-024 Load accepted in the same cycle as the GAP->BITS transfer SHALL leave pending=1 with the new data; transferred frame SHALL be the old shadow.
REQ-025 Frame register SHALL NOT change during BITS or GAP except at REQ-023.
REQ-026 enable=0 in any state SHALL return to IDLE next cycle, dcf_out=0, second=0; shadow and pending SHALL be kept.
REQ-027 With no frame ever loaded, frame register SHALL be all zero with forced bit20=1 and computed parities.
REQ-028 dcf_out, second, minute_start SHALL be registered outputs (no combinational path from inputs).

Reset
REQ-029 reset=0 SHALL asynchronously force: state IDLE, dcf_out 0, second 0, minute_start 0, ready 1, pending 0, prescaler/tenth 0, frame register per REQ-027.
REQ-030 Reset release SHALL be applied synchronously to clk; first activity no earlier than the cycle after release.
REQ-031 Reset mid-frame SHALL abort the frame immediately with no partial pulse after assertion.

Verification (bench uses CLOCK_FREQUENCY=100: tick = 10 cycles, second = 100 cycles)
REQ-032 Load minute=7'h25, hour=6'h13, flags=0, date=0, enable=1 -> 100 cycles dcf_out=0, minute_start pulse, bit0 pulse 10 cycles, bit20 pulse 20 cycles, bit28 (parity of 0x25 = 1) 20 cycles, bit35 (0x13 -> 1) 20 cycles, ready=1 after transfer.
REQ-033 Two consecutive minutes with no new load -> identical 59-bit pulse sequence, second 59 pulse-free both times.
REQ-034 load asserted on exact GAP->BITS cycle with minute=7'h01 -> current frame carries old data, next frame minute=0x01, ready stays 0 until second transfer.
REQ-035 enable dropped at second 30 mid-pulse -> dcf_out=0 and second=0 next cycle; re-enable -> 1 s gap, then full frame.
REQ-036 reset asserted during tenth 1 of a 1-bit -> dcf_out=0 immediately (asynchronous), ready=1, second=0.
REQ-037 load while ready=0 -> ignored; shadow retains first data, observed in next frame.
